// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl
// Bus-master front end for a 256x16 RAM with registered inputs. Converts
// single or burst read/write requests into RAM DATA/ADDRESS/WREN signals and
// returns read data from Q in request order.
//
// Ports:
//   CLK, RST_N             clock (rising edge), asynchronous active-low reset
//   REQ_VALID/REQ_READY    request handshake; READY only while idle
//   REQ_WRITE              1 = write burst, 0 = read burst
//   REQ_ADDR, REQ_LEN      start address, beats minus one
//   WD_VALID/WD_READY      write-beat handshake; READY only during a write burst
//   WD_DATA                write data
//   RD_VALID, RD_DATA      read data strobe and word (no backpressure)
//   BUSY                   controller not idle
//   DONE                   one-cycle pulse at burst completion
//   MEM_DATA, MEM_ADDRESS, MEM_WREN, MEM_Q   RAM interface
module ram_access_ctrl #(
    parameter int WIDTH = 16,
    parameter int ADDR  = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             REQ_VALID,
    output logic             REQ_READY,
    input  logic             REQ_WRITE,
    input  logic [ADDR-1:0]  REQ_ADDR,
    input  logic [ADDR-1:0]  REQ_LEN,
    input  logic             WD_VALID,
    output logic             WD_READY,
    input  logic [WIDTH-1:0] WD_DATA,
    output logic             RD_VALID,
    output logic [WIDTH-1:0] RD_DATA,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] MEM_DATA,
    output logic [ADDR-1:0]  MEM_ADDRESS,
    output logic             MEM_WREN,
    input  logic [WIDTH-1:0] MEM_Q
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

    state_t          state;
    state_t          state_next;
    logic [ADDR-1:0] addr;
    logic [ADDR-1:0] cnt;
    logic            vld_p1;
    logic            vld_p2;
    logic            write_beat;
    logic            last_count;
    logic            drain_done;

    assign REQ_READY  = (state == IDLE);
    assign WD_READY   = (state == WRITE);
    assign BUSY       = (state != IDLE);

    assign write_beat = (state == WRITE) && WD_VALID;
    assign last_count = (cnt == '0);
    // The last read word has been presented once both pipeline slots are empty
    // and RD_VALID is still high from the previous edge.
    assign drain_done = (state == DRAIN) && !vld_p1 && !vld_p2 && RD_VALID;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (REQ_VALID) state_next = REQ_WRITE ? WRITE : READ;
            WRITE:   if (WD_VALID && last_count) state_next = IDLE;
            READ:    if (last_count) state_next = DRAIN;
            DRAIN:   if (drain_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Burst address/count: data-only registers, always loaded before use.
    always_ff @(posedge CLK) begin
        case (state)
            IDLE: begin
                if (REQ_VALID) begin
                    addr <= REQ_ADDR;
                    cnt  <= REQ_LEN;
                end
            end
            WRITE: begin
                if (WD_VALID) begin
                    addr <= addr + ADDR'(1);
                    cnt  <= cnt - ADDR'(1);
                end
            end
            READ: begin
                addr <= addr + ADDR'(1);
                cnt  <= cnt - ADDR'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= IDLE;
            DONE        <= 1'b0;
            MEM_WREN    <= 1'b0;
            MEM_ADDRESS <= '0;
            MEM_DATA    <= '0;
            vld_p1      <= 1'b0;
            vld_p2      <= 1'b0;
            RD_VALID    <= 1'b0;
            RD_DATA     <= '0;
        end else begin
            state    <= state_next;
            DONE     <= (write_beat && last_count) || drain_done;

            // Stage p0: drive the RAM inputs (captured by the RAM next edge).
            MEM_WREN <= write_beat;
            if (write_beat) begin
                MEM_ADDRESS <= addr;
                MEM_DATA    <= WD_DATA;
            end else if (state == READ) begin
                MEM_ADDRESS <= addr;
            end
            vld_p1   <= (state == READ);

            // Stage p1: RAM has captured the address; Q valid after this edge.
            vld_p2   <= vld_p1;

            // Stage p2: register Q; data holds while no word is returning.
            RD_VALID <= vld_p2;
            if (vld_p2) RD_DATA <= MEM_Q;
        end
    end

endmodule

// File: tb/tb_ram_access_ctrl.sv
module tb_ram_access_ctrl;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        REQ_VALID = 1'b0;
    logic        REQ_READY;
    logic        REQ_WRITE = 1'b0;
    logic [7:0]  REQ_ADDR = '0;
    logic [7:0]  REQ_LEN = '0;
    logic        WD_VALID = 1'b0;
    logic        WD_READY;
    logic [15:0] WD_DATA = '0;
    logic        RD_VALID;
    logic [15:0] RD_DATA;
    logic        BUSY;
    logic        DONE;
    logic [15:0] MEM_DATA;
    logic [7:0]  MEM_ADDRESS;
    logic        MEM_WREN;
    logic [15:0] MEM_Q;

    ram_access_ctrl #(.WIDTH(16), .ADDR(8)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WRITE(REQ_WRITE),
        .REQ_ADDR(REQ_ADDR), .REQ_LEN(REQ_LEN),
        .WD_VALID(WD_VALID), .WD_READY(WD_READY), .WD_DATA(WD_DATA),
        .RD_VALID(RD_VALID), .RD_DATA(RD_DATA),
        .BUSY(BUSY), .DONE(DONE),
        .MEM_DATA(MEM_DATA), .MEM_ADDRESS(MEM_ADDRESS), .MEM_WREN(MEM_WREN),
        .MEM_Q(MEM_Q)
    );

    always #5 CLK = ~CLK;

    // RAM model: inputs registered on the rising edge, write committed on the
    // same edge the read address is captured.
    logic [15:0] ram [256];
    logic [7:0]  ram_addr_q = '0;
    always @(posedge CLK) begin
        ram_addr_q <= MEM_ADDRESS;
        if (MEM_WREN) ram[MEM_ADDRESS] <= MEM_DATA;
    end
    assign MEM_Q = ram[ram_addr_q];

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int vec_cnt = 0;
    int miss_cnt = 0;
    int rd_cnt = 0;
    int last_rd_cyc = 0;
    int done_cnt = 0;
    int exp_done = 0;
    int acc_cyc = 0;
    int last_done_cyc = 0;

    logic [15:0] shadow [256];
    logic [15:0] rq[$];
    int          rcq[$];
    logic [23:0] wq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: pops expectations whenever the DUT presents output.
    always @(negedge CLK) begin
        if (RD_VALID) begin
            rd_cnt++;
            last_rd_cyc = cyc;
            if (rq.size() == 0) begin
                chk("rd_unexpected", 32'(RD_VALID), 32'd0);
            end else begin
                chk("rd_data", 32'(RD_DATA), 32'(rq.pop_front()));
                chk("rd_latency", 32'(cyc), 32'(rcq.pop_front()));
            end
        end
        if (MEM_WREN) begin
            if (wq.size() == 0) begin
                chk("wr_unexpected", 32'(MEM_WREN), 32'd0);
            end else begin
                chk("wr_addr_data", 32'({MEM_ADDRESS, MEM_DATA}), 32'(wq.pop_front()));
            end
        end
        if (DONE) done_cnt++;
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic do_req(input logic w, input logic [7:0] a, input logic [7:0] l);
        int n;
        n = 0;
        REQ_VALID = 1'b1; REQ_WRITE = w; REQ_ADDR = a; REQ_LEN = l;
        while (!REQ_READY && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        if (!REQ_READY) begin
            $display("FAIL req_timeout: REQ_READY never rose");
            $fatal(1, "request timeout");
        end
        @(posedge CLK);
        #1 acc_cyc = cyc;
        @(negedge CLK);
        REQ_VALID = 1'b0;
    endtask

    // gaps bit s = 1 inserts a bubble at slot s; data of beat k is base+k.
    task automatic write_burst(input logic [7:0] a, input logic [7:0] l,
                               input logic [31:0] gaps, input logic [15:0] base);
        int beat;
        int s;
        logic v;
        logic [7:0] ad;
        logic [15:0] d;
        do_req(1'b1, a, l);
        beat = 0;
        s = 0;
        while (beat <= int'(l)) begin
            v = !(s < 32 && gaps[s]);
            ad = a + 8'(beat);
            d = base + 16'(beat);
            WD_VALID = v;
            WD_DATA = d;
            if (v) begin
                wq.push_back({ad, d});
                shadow[ad] = d;
                beat++;
            end
            s++;
            @(negedge CLK);
        end
        WD_VALID = 1'b0;
        chk("wr_done_pulse", 32'(DONE), 32'd1);
        chk("wr_busy_end", 32'(BUSY), 32'd0);
        exp_done++;
    endtask

    task automatic push_reads(input logic [7:0] a, input logic [7:0] l);
        logic [7:0] ad;
        for (int k = 0; k <= int'(l); k++) begin
            ad = a + 8'(k);
            rq.push_back(shadow[ad]);
            rcq.push_back(acc_cyc + 3 + k);
        end
    endtask

    task automatic wait_read_done(input logic [7:0] a, input logic [7:0] l);
        int busy_n;
        int early;
        int n;
        int rd0;
        busy_n = 0; early = 0; n = 0; rd0 = rd_cnt;
        while (!DONE && n < 2000) begin
            if (BUSY) busy_n++;
            if (n == 1) chk("rd_first_addr", 32'(MEM_ADDRESS), 32'(a));
            if (REQ_VALID && REQ_READY) early++;
            n++;
            @(negedge CLK);
        end
        chk("rd_done_seen", 32'(DONE), 32'd1);
        last_done_cyc = cyc;
        chk("rd_busy_cycles", 32'(busy_n), 32'(int'(l) + 4));
        chk("rd_done_after_last", 32'(cyc), 32'(last_rd_cyc + 1));
        chk("rd_strobe_count", 32'(rd_cnt - rd0), 32'(int'(l) + 1));
        chk("req_held_early", 32'(early), 32'd0);
        exp_done++;
    endtask

    task automatic read_burst(input logic [7:0] a, input logic [7:0] l);
        do_req(1'b0, a, l);
        push_reads(a, l);
        wait_read_done(a, l);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) shadow[i] = '0;

        // Reset state
        repeat (2) @(negedge CLK);
        chk("rst_wren", 32'(MEM_WREN), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        RST_N = 1'b1;
        @(negedge CLK);
        chk("rst_ready", 32'(REQ_READY), 32'd1);
        chk("rst_rdvalid", 32'(RD_VALID), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        chk("rst_wdready", 32'(WD_READY), 32'd0);

        // Single write then back-to-back read of the same word
        write_burst(8'h10, 8'd0, 32'h0, 16'hBEEF);
        read_burst(8'h10, 8'd0);
        chk("single_rd_data", 32'(RD_DATA), 32'h0000BEEF);

        // Burst write with bubbles: WD_VALID 1,0,1,1,0,1
        @(negedge CLK);
        write_burst(8'h20, 8'd3, 32'b010010, 16'h1110);

        // Burst read pipelining
        @(negedge CLK);
        read_burst(8'h20, 8'd3);
        chk("burst_last_data", 32'(RD_DATA), 32'h00001113);

        // Wrap-around write then read
        @(negedge CLK);
        write_burst(8'hFE, 8'd2, 32'h0, 16'h000A);
        read_burst(8'hFE, 8'd2);
        chk("wrap_last_data", 32'(RD_DATA), 32'h0000000C);

        // Reset in the middle of a write burst
        @(negedge CLK);
        do_req(1'b1, 8'h40, 8'd3);
        WD_VALID = 1'b1;
        WD_DATA = 16'h1234;
        wq.push_back({8'h40, 16'h1234});
        @(negedge CLK);
        WD_VALID = 1'b0;
        chk("midrst_pre_wren", 32'(MEM_WREN), 32'd1);
        chk("midrst_pre_busy", 32'(BUSY), 32'd1);
        #2 RST_N = 1'b0;
        #1;
        chk("midrst_wren", 32'(MEM_WREN), 32'd0);
        chk("midrst_done", 32'(DONE), 32'd0);
        chk("midrst_rdvalid", 32'(RD_VALID), 32'd0);
        chk("midrst_busy", 32'(BUSY), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        chk("midrst_ready", 32'(REQ_READY), 32'd1);
        chk("midrst_no_done", 32'(DONE), 32'd0);

        // Full-depth: fill with value = address, then read all 256 words
        write_burst(8'h00, 8'd255, 32'h0, 16'h0000);
        @(negedge CLK);
        do_req(1'b0, 8'h00, 8'd255);
        push_reads(8'h00, 8'd255);
        REQ_VALID = 1'b1; REQ_WRITE = 1'b0; REQ_ADDR = 8'h05; REQ_LEN = 8'd0;
        wait_read_done(8'h00, 8'd255);
        chk("full_last_data", 32'(RD_DATA), 32'h000000FF);
        chk("held_ready_at_done", 32'(REQ_READY), 32'd1);
        do_req(1'b0, 8'h05, 8'd0);
        chk("held_accept_cycle", 32'(acc_cyc), 32'(last_done_cyc + 1));
        push_reads(8'h05, 8'd0);
        wait_read_done(8'h05, 8'd0);
        chk("held_rd_data", 32'(RD_DATA), 32'h00000005);

        repeat (4) @(negedge CLK);
        chk("done_pulses", 32'(done_cnt), 32'(exp_done));
        chk("rd_queue_empty", 32'(rq.size()), 32'd0);
        chk("wr_queue_empty", 32'(wq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
